aurora_link_supervisor: RTL and testbench

//  Parametrised supervisor for an N-lane Aurora 64B/66B framing channel. Sits between the user TX
//  AXI4-Stream source and the core's s_axi_tx port, and drives the reset-logic request input.

---
 rtl/aurora_link_supervisor.sv | 191 +++++++++++++++++++
 tb/tb_aurora_link_supervisor.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_link_supervisor.sv
// rtl/aurora_link_supervisor.sv - Aurora 64B/66B link bring-up, retrain and TX frame gate
//
// Purpose: brings an N-lane Aurora channel up with a timeout, debounces channel/lane up,
// retrains on hard error, link drop or a soft-error burst, gates the TX stream only on
// frame boundaries and keeps saturating status counters.
// Ports:
//   user_clk, user_rst_n        clock, asynchronous active-low reset
//   enable, clear_cnt           link enable, synchronous clear of the status counters
//   channel_up, lane_up         link status from the core
//   hard_err, soft_err          error indications from the core (level / pulse)
//   s_t*                        upstream TX stream (s_tready out)
//   m_t*                        stream to the core s_axi_tx (m_tready in)
//   link_reset_req              reset request to the support reset logic
//   link_ok, state_o            registered link status
//   retrain_cnt .. drop_frm_cnt saturating status counters
module aurora_link_supervisor #(
    parameter int NUM_LANES      = 2,
    parameter int DATA_W         = 64,
    parameter int RESET_HOLD_CYC = 128,
    parameter int TIMEOUT_CYC    = 1000000,
    parameter int UP_STABLE_CYC  = 1024,
    parameter int SOFT_ERR_LIMIT = 16,
    parameter int SOFT_ERR_WIN   = 65536,
    parameter int CNT_W          = 16
) (
    input  logic                 user_clk,
    input  logic                 user_rst_n,
    input  logic                 enable,
    input  logic                 clear_cnt,
    input  logic                 channel_up,
    input  logic [NUM_LANES-1:0] lane_up,
    input  logic                 hard_err,
    input  logic                 soft_err,
    input  logic [DATA_W-1:0]    s_tdata,
    input  logic [DATA_W/8-1:0]  s_tkeep,
    input  logic                 s_tlast,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [DATA_W-1:0]    m_tdata,
    output logic [DATA_W/8-1:0]  m_tkeep,
    output logic                 m_tlast,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 link_reset_req,
    output logic                 link_ok,
    output logic [2:0]           state_o,
    output logic [CNT_W-1:0]     retrain_cnt,
    output logic [CNT_W-1:0]     hard_err_cnt,
    output logic [CNT_W-1:0]     soft_err_cnt,
    output logic [CNT_W-1:0]     drop_frm_cnt
);
    localparam int TMR_MAX = (TIMEOUT_CYC > RESET_HOLD_CYC)
        ? ((TIMEOUT_CYC > UP_STABLE_CYC) ? TIMEOUT_CYC : UP_STABLE_CYC)
        : ((RESET_HOLD_CYC > UP_STABLE_CYC) ? RESET_HOLD_CYC : UP_STABLE_CYC);
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam int WIN_W = $clog2(SOFT_ERR_WIN + 1);
    localparam int SE_W  = $clog2(SOFT_ERR_LIMIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RST     = 3'd1,
        ST_WAIT_UP = 3'd2,
        ST_STABLE  = 3'd3,
        ST_RUN     = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [SE_W-1:0]    se_q, se_d;
    logic               link_reset_req_q, link_ok_q;
    logic               hard_prev_q;
    logic               in_frame_q, in_frame_d;
    logic               discard_q, discard_d;
    logic [CNT_W-1:0]   retrain_q, hard_q, soft_q, drop_q;

    logic up, burst, fault, win_end, retrain_inc, pass, accept, drop_start;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign up    = channel_up & (&lane_up);
    assign fault = hard_err | ~up | burst;

    // Soft-error burst: in-window count restarts at each window end and after each burst.
    // A pulse on the last window cycle still counts toward the ending window.
    assign win_end = (win_q == WIN_W'(SOFT_ERR_WIN - 1));
    assign win_d   = win_end ? '0 : win_q + WIN_W'(1);
    assign burst   = soft_err & (se_q == SE_W'(SOFT_ERR_LIMIT - 1));
    assign se_d    = (win_end | burst) ? '0 : se_q + SE_W'(soft_err);

    always_comb begin
        state_d     = state_q;
        retrain_inc = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RST;
                ST_RST: begin
                    if (tmr_q == TMR_W'(RESET_HOLD_CYC - 1)) state_d = ST_WAIT_UP;
                end
                ST_WAIT_UP: begin
                    if (up) begin
                        state_d = ST_STABLE;
                    end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                        state_d     = ST_RST;
                        retrain_inc = 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!up) state_d = ST_WAIT_UP;
                    else if (tmr_q == TMR_W'(UP_STABLE_CYC - 1)) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (fault) begin
                        state_d     = ST_RST;
                        retrain_inc = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Time-in-state; restarts on every transition, idle in the untimed states.
    assign tmr_d = ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_RUN))
                   ? '0 : tmr_q + TMR_W'(1);

    // TX gate: the stream only opens in RUN and never in the middle of a frame.
    assign pass       = (state_q == ST_RUN) & ~discard_q;
    assign m_tdata    = s_tdata;
    assign m_tkeep    = s_tkeep;
    assign m_tlast    = s_tlast;
    assign m_tvalid   = s_tvalid & pass;
    assign s_tready   = discard_q | (m_tready & pass);
    assign accept     = s_tvalid & s_tready;
    assign in_frame_d = accept ? ~s_tlast : in_frame_q;
    // in_frame_d covers a beat accepted on the very cycle the link leaves RUN.
    assign drop_start = (state_q == ST_RUN) & (state_d != ST_RUN) & in_frame_d & ~discard_q;
    assign discard_d  = discard_q ? ~(accept & s_tlast) : drop_start;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q          <= ST_IDLE;
            tmr_q            <= '0;
            win_q            <= '0;
            se_q             <= '0;
            link_reset_req_q <= 1'b1;
            link_ok_q        <= 1'b0;
            hard_prev_q      <= 1'b0;
            in_frame_q       <= 1'b0;
            discard_q        <= 1'b0;
            retrain_q        <= '0;
            hard_q           <= '0;
            soft_q           <= '0;
            drop_q           <= '0;
        end else begin
            state_q          <= state_d;
            tmr_q            <= tmr_d;
            win_q            <= win_d;
            se_q             <= se_d;
            link_reset_req_q <= (state_d == ST_IDLE) || (state_d == ST_RST);
            link_ok_q        <= (state_d == ST_RUN);
            hard_prev_q      <= hard_err;
            in_frame_q       <= in_frame_d;
            discard_q        <= discard_d;
            if (clear_cnt) begin
                retrain_q <= '0;
                hard_q    <= '0;
                soft_q    <= '0;
                drop_q    <= '0;
            end else begin
                retrain_q <= sat_inc(retrain_q, retrain_inc);
                hard_q    <= sat_inc(hard_q, hard_err & ~hard_prev_q);
                soft_q    <= sat_inc(soft_q, soft_err);
                drop_q    <= sat_inc(drop_q, drop_start);
            end
        end
    end

    assign link_reset_req = link_reset_req_q;
    assign link_ok        = link_ok_q;
    assign state_o        = state_q;
    assign retrain_cnt    = retrain_q;
    assign hard_err_cnt   = hard_q;
    assign soft_err_cnt   = soft_q;
    assign drop_frm_cnt   = drop_q;

endmodule

// File: tb/tb_aurora_link_supervisor.sv
// tb/tb_aurora_link_supervisor.sv - directed and randomized bench for aurora_link_supervisor
module tb_aurora_link_supervisor;
    localparam int HOLD = 4, TMO = 64, STAB = 8, SLIM = 3, SWIN = 32, CW = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int S_IDLE = 0, S_RST = 1, S_WAIT = 2, S_STAB = 3, S_RUN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0, clear_cnt = 1'b0, channel_up = 1'b0;
    logic [1:0]  lane_up = 2'b00;
    logic        hard_err = 1'b0, soft_err = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tlast = 1'b0, s_tvalid = 1'b0, m_tready = 1'b0;
    logic        s_tready, m_tlast, m_tvalid, link_reset_req, link_ok;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic [2:0]  state_o;
    logic [CW-1:0] retrain_cnt, hard_err_cnt, soft_err_cnt, drop_frm_cnt;

    always #5 clk = ~clk;

    aurora_link_supervisor #(
        .NUM_LANES(2), .DATA_W(64), .RESET_HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO),
        .UP_STABLE_CYC(STAB), .SOFT_ERR_LIMIT(SLIM), .SOFT_ERR_WIN(SWIN), .CNT_W(CW)
    ) dut (
        .user_clk(clk), .user_rst_n(rst_n), .enable(enable), .clear_cnt(clear_cnt),
        .channel_up(channel_up), .lane_up(lane_up), .hard_err(hard_err), .soft_err(soft_err),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .link_reset_req(link_reset_req),
        .link_ok(link_ok), .state_o(state_o), .retrain_cnt(retrain_cnt),
        .hard_err_cnt(hard_err_cnt), .soft_err_cnt(soft_err_cnt), .drop_frm_cnt(drop_frm_cnt)
    );

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: link status, window bookkeeping, frame bookkeeping, counters.
    int m_st, m_age, m_win_pos, m_soft;
    int m_retrain, m_hard, m_softc, m_drop;
    bit m_prev_hard, m_infrm, m_disc;

    function automatic int sat(input int v, input bit inc);
        return (inc && v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_age = 0; m_win_pos = 0; m_soft = 0;
        m_retrain = 0; m_hard = 0; m_softc = 0; m_drop = 0;
        m_prev_hard = 0; m_infrm = 0; m_disc = 0;
    endtask

    task automatic check_outputs();
        bit pass;
        pass = (m_st == S_RUN) && !m_disc;
        check("state", state_o, m_st);
        check("link_reset_req", link_reset_req, (m_st == S_IDLE) || (m_st == S_RST));
        check("link_ok", link_ok, m_st == S_RUN);
        check("retrain_cnt", retrain_cnt, m_retrain);
        check("hard_err_cnt", hard_err_cnt, m_hard);
        check("soft_err_cnt", soft_err_cnt, m_softc);
        check("drop_frm_cnt", drop_frm_cnt, m_drop);
        check("m_tvalid", m_tvalid, s_tvalid && pass);
        check("s_tready", s_tready, m_disc || (m_tready && pass));
        check("m_tdata", m_tdata, s_tdata);
        check("m_tkeep", m_tkeep, s_tkeep);
        check("m_tlast", m_tlast, s_tlast);
    endtask

    task automatic model_step();
        bit up, burst, acc, pass, retrain, rise, drop;
        int nxt;
        up    = channel_up && (lane_up == 2'b11);
        pass  = (m_st == S_RUN) && !m_disc;
        acc   = s_tvalid && (m_disc || (m_tready && pass));
        burst = 0;
        if (soft_err) m_soft++;
        if (m_soft >= SLIM) begin
            burst  = 1;
            m_soft = 0;
        end
        if (m_win_pos == SWIN - 1) m_soft = 0;
        m_win_pos = (m_win_pos + 1) % SWIN;

        nxt = m_st;
        retrain = 0;
        if (!enable) nxt = S_IDLE;
        else if (m_st == S_IDLE) nxt = S_RST;
        else if (m_st == S_RST) begin
            if (m_age + 1 >= HOLD) nxt = S_WAIT;
        end else if (m_st == S_WAIT) begin
            if (up) nxt = S_STAB;
            else if (m_age + 1 >= TMO) begin nxt = S_RST; retrain = 1; end
        end else if (m_st == S_STAB) begin
            if (!up) nxt = S_WAIT;
            else if (m_age + 1 >= STAB) nxt = S_RUN;
        end else if (hard_err || !up || burst) begin
            nxt = S_RST; retrain = 1;
        end
        m_age = (nxt == m_st) ? m_age + 1 : 0;

        if (acc) m_infrm = !s_tlast;
        drop = 0;
        if (m_disc) begin
            if (acc && s_tlast) m_disc = 0;
        end else if (m_st == S_RUN && nxt != S_RUN && m_infrm) begin
            m_disc = 1; drop = 1;
        end

        rise = hard_err && !m_prev_hard;
        m_prev_hard = hard_err;
        if (clear_cnt) begin
            m_retrain = 0; m_hard = 0; m_softc = 0; m_drop = 0;
        end else begin
            m_retrain = sat(m_retrain, retrain);
            m_hard    = sat(m_hard, rise);
            m_softc   = sat(m_softc, soft_err);
            m_drop    = sat(m_drop, drop);
        end
        m_st = nxt;
    endtask

    // Inputs are set at the falling edge; this checks, advances the model and clocks once.
    task automatic tick();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (state_o != 3'd4 && n < 300) begin
            tick();
            n++;
        end
        check("wait_run", state_o, 3'd4);
    endtask

    task automatic pulse_clear();
        clear_cnt = 1'b1;
        tick();
        clear_cnt = 1'b0;
    endtask

    task automatic align_window();
        int n;
        n = 0;
        while (m_win_pos != 0 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n_rst, n_rst_req, n_stab, sent_seq, got_seq;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_state", state_o, 3'd0);
        check("rst_reset_req", link_reset_req, 1'b1);
        check("rst_link_ok", link_ok, 1'b0);
        check("rst_retrain", retrain_cnt, 0);
        check("rst_drop", drop_frm_cnt, 0);

        // 1. Bring-up with up held
        enable = 1'b1; channel_up = 1'b1; lane_up = 2'b11;
        n_rst = 0; n_rst_req = 0; n_stab = 0;
        for (int i = 0; i < 100 && state_o != 3'd4; i++) begin
            if (state_o == 3'd1) n_rst++;
            if (state_o == 3'd1 && link_reset_req) n_rst_req++;
            if (state_o == 3'd3) n_stab++;
            tick();
        end
        check("bringup_rst_cycles", n_rst, HOLD);
        check("bringup_req_cycles", n_rst_req, HOLD);
        check("bringup_stable_cycles", n_stab, STAB);
        check("bringup_link_ok", link_ok, 1'b1);
        check("bringup_retrain", retrain_cnt, 0);

        // 2. Timeout with one lane down
        enable = 1'b0; tick();
        enable = 1'b1; lane_up = 2'b01;
        repeat (1 + 3 * (HOLD + TMO)) tick();
        check("timeout_state", state_o, 3'd1);
        check("timeout_retrain", retrain_cnt, 3);

        // 3. One-cycle glitch in STABLE
        lane_up = 2'b11;
        clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
        repeat (HOLD) tick();
        check("glitch_in_stable", state_o, 3'd3);
        repeat (4) tick();
        channel_up = 1'b0; tick(); channel_up = 1'b1;
        check("glitch_back_wait", state_o, 3'd2);
        repeat (STAB) tick();
        check("glitch_still_stable", state_o, 3'd3);
        tick();
        check("glitch_run", state_o, 3'd4);

        // 4. Soft-error burst, then a sub-threshold rate
        pulse_clear();
        align_window();
        for (int p = 0; p < 9; p++) begin
            soft_err = (p == 2 || p == 5 || p == 8);
            tick();
        end
        soft_err = 1'b0;
        check("burst_state", state_o, 3'd1);
        check("burst_retrain", retrain_cnt, 1);
        check("burst_soft_cnt", soft_err_cnt, 3);
        wait_run();
        pulse_clear();
        align_window();
        for (int p = 0; p < 3 * SWIN; p++) begin
            soft_err = ((p % SWIN) == 7 || (p % SWIN) == 29);
            tick();
        end
        soft_err = 1'b0;
        check("subburst_state", state_o, 3'd4);
        check("subburst_retrain", retrain_cnt, 0);

        // 5. Fault in the middle of a 5-beat frame
        pulse_clear();
        m_tready = 1'b1;
        for (int b = 1; b <= 2; b++) begin
            s_tvalid = 1'b1; s_tdata = 64'(b); s_tlast = 1'b0; #1;
            check("mf_head_valid", m_tvalid, 1'b1);
            tick();
        end
        s_tvalid = 1'b0; hard_err = 1'b1; tick(); hard_err = 1'b0;
        check("mf_state", state_o, 3'd1);
        check("mf_drop", drop_frm_cnt, 1);
        for (int b = 3; b <= 5; b++) begin
            s_tvalid = 1'b1; s_tdata = 64'(b); s_tlast = (b == 5); #1;
            check("mf_tail_ready", s_tready, 1'b1);
            check("mf_tail_valid", m_tvalid, 1'b0);
            tick();
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        check("mf_hard_cnt", hard_err_cnt, 1);
        wait_run();
        for (int b = 1; b <= 5; b++) begin
            s_tvalid = 1'b1; s_tdata = 64'(100 + b); s_tlast = (b == 5); #1;
            check("mf_next_valid", m_tvalid, 1'b1);
            check("mf_next_ready", s_tready, 1'b1);
            tick();
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        check("mf_drop_after", drop_frm_cnt, 1);

        // 6. Backpressure: every accepted beat arrives once, in order
        sent_seq = 0; got_seq = 0;
        for (int i = 0; i < 200; i++) begin
            m_tready = $urandom_range(0, 1);
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = 64'(sent_seq);
            s_tlast  = ($urandom_range(0, 3) == 0);
            #1;
            if (m_tvalid && m_tready) begin
                check("bp_data", m_tdata, 64'(got_seq));
                got_seq++;
            end
            if (s_tvalid && s_tready) sent_seq++;
            tick();
        end
        s_tvalid = 1'b0;
        check("bp_count", got_seq, sent_seq);
        check("bp_state", state_o, 3'd4);

        // Counter saturation and clear priority
        pulse_clear();
        repeat (5) begin
            hard_err = 1'b1; tick();
            hard_err = 1'b0; tick();
        end
        check("sat_hard_cnt", hard_err_cnt, CMAX);
        hard_err = 1'b1; clear_cnt = 1'b1; tick();
        hard_err = 1'b0; clear_cnt = 1'b0;
        check("clear_wins", hard_err_cnt, 0);

        // 7. Randomized operation with an asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs();
                check("async_rst_state", state_o, 3'd0);
                check("async_rst_req", link_reset_req, 1'b1);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
            enable     = ($urandom_range(0, 199) != 0);
            channel_up = ($urandom_range(0, 49) != 0);
            lane_up    = ($urandom_range(0, 59) == 0) ? 2'b01 : 2'b11;
            hard_err   = ($urandom_range(0, 99) == 0);
            soft_err   = ($urandom_range(0, 11) == 0);
            clear_cnt  = ($urandom_range(0, 149) == 0);
            s_tvalid   = $urandom_range(0, 1);
            s_tdata    = {$urandom, $urandom};
            s_tkeep    = 8'($urandom);
            s_tlast    = ($urandom_range(0, 3) == 0);
            m_tready   = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
